// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths, flag bit indices and constants for reg_file, ALU and branch unit
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int FLAG_W = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_P = 0;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/flag_reg.sv
// flag_reg: enable register with async reset and optional write-first bypass of d onto q
module flag_reg #(
  parameter int W = 4,
  parameter bit BYPASS = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r;
  always_ff @(posedge clk or posedge rst)
    if (rst) r <= '0;
    else if (en) r <= d;
  assign q = (BYPASS && en && !rst) ? d : r;
endmodule

// File: rtl/reg_file.sv
// reg_file: 16x16 register file (R0 hardwired 0) plus NZCP flag register; REG_FILE_BYPASS_EN selects write-first reads
import cpu_pkg::*;
module reg_file #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int FLAG_W = cpu_pkg::FLAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              flag_we,
  input  logic [FLAG_W-1:0] flag_in,
  output logic [FLAG_W-1:0] flags
);
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic wr_hit;
  assign wr_hit = we && !rst && (rd_addr != REG_ZERO);
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else if (wr_hit) regs[rd_addr] <= rd_data;
  // bypass is gated by rst so reads stay 0 while reset is held
  always_comb begin
    rs_data = (rs_addr == REG_ZERO) ? '0 : (BYPASS && wr_hit && rs_addr == rd_addr) ? rd_data : regs[rs_addr];
    rt_data = (rt_addr == REG_ZERO) ? '0 : (BYPASS && wr_hit && rt_addr == rd_addr) ? rd_data : regs[rt_addr];
  end
  flag_reg #(.W(FLAG_W), .BYPASS(BYPASS)) u_flag_reg (
    .clk(clk),
    .rst(rst),
    .en(flag_we),
    .d(flag_in),
    .q(flags)
  );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed table-driven check of reg_file plus hand-written reset, R0, bypass and sweep sequences
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0;
  logic [15:0] rs_data, rt_data, rd_data = '0;
  logic        we = 1'b0, flag_we = 1'b0;
  logic [3:0]  flag_in = '0, flags;
  int total = 0, bad = 0;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  reg_file dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rs_data(rs_data),
    .rt_addr(rt_addr), .rt_data(rt_data),
    .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
    .flag_we(flag_we), .flag_in(flag_in), .flags(flags)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        flag_we;
    logic [3:0]  flag_in;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [15:0] exp_rs;
    logic [15:0] exp_rt;
    logic [3:0]  exp_flags;
  } vec_t;
  vec_t vecs [6];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    vecs[0] = '{1'b1, 4'd3,  16'h1234, 1'b0, 4'b0000, 4'd3,  4'd3, 16'h1234, 16'h1234, 4'b0000};
    vecs[1] = '{1'b1, 4'd0,  16'hFFFF, 1'b0, 4'b0000, 4'd0,  4'd3, 16'h0000, 16'h1234, 4'b0000};
    vecs[2] = '{1'b1, 4'd5,  16'hBEEF, 1'b1, 4'b0101, 4'd5,  4'd0, 16'hBEEF, 16'h0000, 4'b0101};
    vecs[3] = '{1'b0, 4'd6,  16'h5555, 1'b0, 4'b1010, 4'd6,  4'd5, 16'h0000, 16'hBEEF, 4'b0101};
    vecs[4] = '{1'b1, 4'd15, 16'hFFFF, 1'b1, 4'b1010, 4'd15, 4'd3, 16'hFFFF, 16'h1234, 4'b1010};
    vecs[5] = '{1'b1, 4'd7,  16'h0001, 1'b0, 4'b0110, 4'd7,  4'd0, 16'h0001, 16'h0000, 4'b1010};
    #1 rst = 1'b1;
    #2;
    chk("reset_rs", rs_data, 16'h0000);
    chk("reset_flags", {12'h0, flags}, 16'h0000);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      we = vecs[i].we; rd_addr = vecs[i].rd_addr; rd_data = vecs[i].rd_data;
      flag_we = vecs[i].flag_we; flag_in = vecs[i].flag_in;
      rs_addr = vecs[i].rs_addr; rt_addr = vecs[i].rt_addr;
      @(posedge clk);
      #1 we = 1'b0; flag_we = 1'b0;
      #1;
      chk($sformatf("vec%0d_rs", i), rs_data, vecs[i].exp_rs);
      chk($sformatf("vec%0d_rt", i), rt_data, vecs[i].exp_rt);
      chk($sformatf("vec%0d_flags", i), {12'h0, flags}, {12'h0, vecs[i].exp_flags});
    end
    @(negedge clk);
    we = 1'b1; rd_addr = 4'd7; rd_data = 16'h00AA; rs_addr = 4'd7;
    flag_we = 1'b1; flag_in = 4'b0011;
    #1;
    chk("same_cycle_rs", rs_data, BYP ? 16'h00AA : 16'h0001);
    chk("same_cycle_flags", {12'h0, flags}, BYP ? 16'h0003 : 16'h000A);
    @(posedge clk);
    #1 we = 1'b0; flag_we = 1'b0;
    #1;
    chk("after_edge_rs", rs_data, 16'h00AA);
    chk("after_edge_flags", {12'h0, flags}, 16'h0003);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      we = 1'b1; rd_addr = 4'(i); rd_data = 16'(16'h1111 * i);
    end
    @(negedge clk) we = 1'b0;
    for (int i = 1; i < 16; i++) begin
      rs_addr = 4'(i); rt_addr = 4'(16 - i);
      #1;
      chk($sformatf("sweep_rs%0d", i), rs_data, 16'(16'h1111 * i));
      chk($sformatf("sweep_rt%0d", 16 - i), rt_data, 16'(16'h1111 * (16 - i)));
    end
    rs_addr = 4'd0;
    #1 chk("r0_after_sweep", rs_data, 16'h0000);
    @(negedge clk);
    we = 1'b1; rd_addr = 4'd5; rd_data = 16'hBEEF;
    @(posedge clk);
    #1 we = 1'b0; rs_addr = 4'd5;
    #1 chk("r5_beef", rs_data, 16'hBEEF);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_rs", rs_data, 16'h0000);
    chk("async_reset_flags", {12'h0, flags}, 16'h0000);
    we = 1'b1; rd_addr = 4'd9; rd_data = 16'h1234; rs_addr = 4'd9; rt_addr = 4'd9;
    @(posedge clk);
    #1;
    chk("write_in_reset_rs", rs_data, 16'h0000);
    chk("write_in_reset_rt", rt_data, 16'h0000);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 we = 1'b0;
    #1;
    chk("first_write_after_reset", rs_data, 16'h1234);
    rs_addr = 4'd5;
    #1 chk("r5_still_cleared", rs_data, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
